// File: rtl/zflag_pkg.sv
// Shared types and constants for the multi-core zero/negative flag bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   zstate_t        query FSM states (IDLE, WAIT, RESULT)
//   DEF_WIDTH       default ALU data width per core
//   DEF_CORE_COUNT  default number of cores
//   ALL_MODE        decision = AND of masked Z flags
//   ANY_MODE        decision = OR of masked Z flags
package zflag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } zstate_t;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_CORE_COUNT = 4;

    localparam logic ALL_MODE = 1'b1;
    localparam logic ANY_MODE = 1'b0;

endpackage : zflag_pkg

// File: rtl/zflag_cell.sv
// One core's Z / N flags plus a "fresh" bit marking an unconsumed write.
// Latency: flags update on the edge where wrEn is sampled; zNext shows the post-edge Z value combinationally.
// Backpressure: none; a write is always accepted and beats a simultaneous fresh clear.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   wrEn       store flags derived from dataIn and mark the cell fresh
//   clrFresh   drop the fresh bit (ignored when wrEn is also high)
//   dataIn     this core's ALU result
//   zFlag      registered zero flag
//   nFlag      registered negative flag (MSB of the last written result)
//   fresh      a write has happened since the last consuming decision
//   zNext      Z value as it will be after this edge
module zflag_cell #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic             clrFresh,
    input  logic [WIDTH-1:0] dataIn,
    output logic             zFlag,
    output logic             nFlag,
    output logic             fresh,
    output logic             zNext
);

    logic zWr;

    assign zWr   = (dataIn == '0);

    // Lets the top register a decision that already reflects a write landing
    // on the same edge that completes the query.
    assign zNext = wrEn ? zWr : zFlag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zFlag <= 1'b0;
            nFlag <= 1'b0;
            fresh <= 1'b0;
        end else if (wrEn) begin
            zFlag <= zWr;
            nFlag <= dataIn[WIDTH-1];
            fresh <= 1'b1;
        end else if (clrFresh) begin
            fresh <= 1'b0;
        end
    end

endmodule : zflag_cell

// File: rtl/zflag_bank.sv
// Per-core Z/N flag bank with a query FSM that combines masked Z flags into one branch decision.
// Latency: query at edge t -> decisionValid during cycle t+2 at best; WAIT holds until every masked core is fresh.
// Backpressure: busy is high in WAIT and RESULT; queries arriving while busy are dropped, never queued.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   dataIn         per-core ALU results, core i at [i*WIDTH +: WIDTH]
//   wrEn           per-core flag write enable (accepted in every state)
//   query          decision request, accepted only in IDLE
//   coreMask       participating cores, latched with the query
//   allMode        1: AND of masked Z flags, 0: OR; latched with the query
//   Zout, Nout     per-core zero / negative flags
//   busy           FSM is in WAIT or RESULT
//   decisionValid  one-cycle pulse carrying decisionZ
//   decisionZ      combined decision, meaningful only with decisionValid
//   timedOut       (ZFLAG_TIMEOUT_EN only) decision was forced by the WAIT timeout
//
// Build option: define ZFLAG_TIMEOUT_EN to bound WAIT to TIMEOUT cycles and add the timedOut port.
module zflag_bank
    import zflag_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CORE_COUNT = DEF_CORE_COUNT,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CORE_COUNT*WIDTH-1:0] dataIn,
    input  logic [CORE_COUNT-1:0]       wrEn,
    input  logic                        query,
    input  logic [CORE_COUNT-1:0]       coreMask,
    input  logic                        allMode,
    output logic [CORE_COUNT-1:0]       Zout,
    output logic [CORE_COUNT-1:0]       Nout,
    output logic                        busy,
    output logic                        decisionValid,
`ifdef ZFLAG_TIMEOUT_EN
    output logic                        decisionZ,
    output logic                        timedOut
`else
    output logic                        decisionZ
`endif
);

    if (CORE_COUNT < 1 || CORE_COUNT > 16 || TIMEOUT < 1) begin : gBadParam
        $error("zflag_bank: CORE_COUNT must be 1..16 and TIMEOUT must be >= 1");
    end

    zstate_t               state;
    logic [CORE_COUNT-1:0] mask;
    logic                  mode;
    logic [CORE_COUNT-1:0] fresh;
    logic [CORE_COUNT-1:0] zNext;
    logic [CORE_COUNT-1:0] clrFresh;
    logic                  complete;
    logic                  decisionComb;

    // ---------------------------------------------------------------
    // Flag cells
    // ---------------------------------------------------------------
    for (genvar i = 0; i < CORE_COUNT; i++) begin : gCell
        zflag_cell #(
            .WIDTH (WIDTH)
        ) uCell (
            .clk      (clk),
            .rst      (rst),
            .wrEn     (wrEn[i]),
            .clrFresh (clrFresh[i]),
            .dataIn   (dataIn[i*WIDTH +: WIDTH]),
            .zFlag    (Zout[i]),
            .nFlag    (Nout[i]),
            .fresh    (fresh[i]),
            .zNext    (zNext[i])
        );
    end

    // A write landing this cycle counts as fresh, so the query can complete
    // on the same edge that delivers the last result.
    assign complete = (((fresh | wrEn) & mask) == mask);

    // Unmasked cores are forced to 1 for AND and to 0 for OR, which gives the
    // vacuous-truth result for an empty mask without a special case.
    assign decisionComb = (mode == ALL_MODE) ? (&(zNext | ~mask))
                                             : (|(zNext & mask));

    // Leaving RESULT consumes the masked cores' results; a simultaneous write
    // keeps its fresh bit because the cell gives wrEn priority.
    assign clrFresh = (state == RESULT) ? mask : '0;

    assign busy = (state != IDLE);

`ifdef ZFLAG_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] waitCnt;
`endif

    // ---------------------------------------------------------------
    // Query FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= '0;
            mode          <= ANY_MODE;
            decisionValid <= 1'b0;
            decisionZ     <= 1'b0;
`ifdef ZFLAG_TIMEOUT_EN
            waitCnt       <= '0;
            timedOut      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    decisionValid <= 1'b0;
`ifdef ZFLAG_TIMEOUT_EN
                    timedOut      <= 1'b0;
`endif
                    if (query) begin
                        mask    <= coreMask;
                        mode    <= allMode;
                        state   <= WAIT;
`ifdef ZFLAG_TIMEOUT_EN
                        waitCnt <= '0;
`endif
                    end
                end

                WAIT: begin
                    if (complete) begin
                        state         <= RESULT;
                        decisionValid <= 1'b1;
                        decisionZ     <= decisionComb;
`ifdef ZFLAG_TIMEOUT_EN
                    end else if (waitCnt == CNT_LAST) begin
                        // This edge is the TIMEOUT-th spent in WAIT: decide
                        // on whatever flags are held, stale or not.
                        state         <= RESULT;
                        decisionValid <= 1'b1;
                        decisionZ     <= decisionComb;
                        timedOut      <= 1'b1;
                    end else begin
                        waitCnt       <= waitCnt + 1'b1;
`endif
                    end
                end

                RESULT: begin
                    decisionValid <= 1'b0;
`ifdef ZFLAG_TIMEOUT_EN
                    timedOut      <= 1'b0;
`endif
                    state         <= IDLE;
                end

                default: begin
                    decisionValid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule : zflag_bank

// File: tb/tb_zflag_bank.sv
// Directed bench for zflag_bank: per-cycle comparison against a behavioural
// model plus hand-computed literal expectations for each scenario.
module tb_zflag_bank;

    localparam int W  = 12;
    localparam int CC = 4;
`ifdef ZFLAG_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic            clk;
    logic            rst;
    logic [CC*W-1:0] dataIn;
    logic [CC-1:0]   wrEn;
    logic            query;
    logic [CC-1:0]   coreMask;
    logic            allMode;
    logic [CC-1:0]   Zout;
    logic [CC-1:0]   Nout;
    logic            busy;
    logic            decisionValid;
    logic            decisionZ;
`ifdef ZFLAG_TIMEOUT_EN
    logic            timedOut;
`endif

    int checks = 0;
    int errors = 0;

    zflag_bank #(
        .WIDTH      (W),
        .CORE_COUNT (CC),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dataIn        (dataIn),
        .wrEn          (wrEn),
        .query         (query),
        .coreMask      (coreMask),
        .allMode       (allMode),
        .Zout          (Zout),
        .Nout          (Nout),
        .busy          (busy),
        .decisionValid (decisionValid),
`ifdef ZFLAG_TIMEOUT_EN
        .decisionZ     (decisionZ),
        .timedOut      (timedOut)
`else
        .decisionZ     (decisionZ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: flags per core, and a query tracked as
    // "pending until every masked core has a fresh result".
    // ---------------------------------------------------------------
    bit          mZ [CC];
    bit          mN [CC];
    bit          mF [CC];
    int          mPhase;   // 0 no query, 1 waiting for results, 2 decision shown
    bit [CC-1:0] mMask;
    bit          mAll;
    bit          mDecZ;
    bit          mTo;
    int          mCnt;

    always @(posedge clk or posedge rst) begin : model
        int missing, zeros, members;
        if (rst) begin
            for (int i = 0; i < CC; i++) begin
                mZ[i] = 0; mN[i] = 0; mF[i] = 0;
            end
            mPhase = 0; mMask = '0; mAll = 0; mDecZ = 0; mTo = 0; mCnt = 0;
        end else begin
            for (int i = 0; i < CC; i++) begin
                if (wrEn[i]) begin
                    mZ[i] = (dataIn[i*W +: W] == 0);
                    mN[i] = dataIn[i*W + W - 1];
                    mF[i] = 1;
                end
            end
            case (mPhase)
                0: if (query) begin
                    mMask = coreMask; mAll = allMode; mPhase = 1; mCnt = 0;
                end
                1: begin
                    missing = 0; zeros = 0; members = 0;
                    for (int i = 0; i < CC; i++) begin
                        if (mMask[i]) begin
                            members++;
                            if (!mF[i]) missing++;
                            if (mZ[i])  zeros++;
                        end
                    end
                    if (missing != 0) mCnt++;
`ifdef ZFLAG_TIMEOUT_EN
                    if (missing == 0 || mCnt == TO) begin
`else
                    if (missing == 0) begin
`endif
                        mDecZ  = mAll ? (zeros == members) : (zeros > 0);
                        mTo    = (missing != 0);
                        mPhase = 2;
                    end
                end
                default: begin
                    for (int i = 0; i < CC; i++)
                        if (mMask[i] && !wrEn[i]) mF[i] = 0;
                    mPhase = 0;
                    mTo    = 0;
                end
            endcase
        end
    end

    bit modelOn = 0;

    always @(negedge clk) begin : compare
        logic [CC-1:0] ez, en;
        if (modelOn && !rst) begin
            for (int i = 0; i < CC; i++) begin
                ez[i] = mZ[i];
                en[i] = mN[i];
            end
            check("cmp_zout", {28'b0, Zout}, {28'b0, ez});
            check("cmp_nout", {28'b0, Nout}, {28'b0, en});
            check("cmp_busy", {31'b0, busy}, {31'b0, (mPhase != 0)});
            check("cmp_valid", {31'b0, decisionValid}, {31'b0, (mPhase == 2)});
            if (mPhase == 2)
                check("cmp_decz", {31'b0, decisionZ}, {31'b0, mDecZ});
`ifdef ZFLAG_TIMEOUT_EN
            check("cmp_timedout", {31'b0, timedOut}, {31'b0, mTo});
`endif
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    function automatic logic [CC*W-1:0] pack(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                             input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Present one cycle of inputs, let the edge take them, then return to idle inputs.
    task automatic step(input logic [CC-1:0] we, input logic [CC*W-1:0] d,
                        input logic q, input logic [CC-1:0] m, input logic am);
        wrEn = we; dataIn = d; query = q; coreMask = m; allMode = am;
        @(posedge clk);
        #2;
        wrEn = '0; query = 1'b0;
    endtask

    task automatic idle();
        step('0, '0, 1'b0, '0, 1'b0);
    endtask

    int pulses;
    int seen;
    logic toFlag;
    logic toZ;

    initial begin
        rst = 0; dataIn = '0; wrEn = '0; query = 0; coreMask = '0; allMode = 0;
        #1 rst = 1;
        #12;
        @(posedge clk); #2 rst = 0;
        modelOn = 1;

        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_valid", {31'b0, decisionValid}, 32'd0);

        // Asynchronous reset mid-cycle wipes a stored flag at once.
        step(4'b0001, pack(12'h000, 12'h000, 12'h000, 12'h000), 1'b0, '0, 1'b0);
        check("pre_rst_z", {28'b0, Zout}, 32'h1);
        #1 rst = 1;
        #1;
        check("async_rst_z", {28'b0, Zout}, 32'h0);
        check("async_rst_n", {28'b0, Nout}, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_decz", {31'b0, decisionZ}, 32'd0);
        @(posedge clk); #2 rst = 0;

        // Flag derivation: zero -> Z, MSB set -> N, 5 -> neither.
        step(4'b0111, pack(12'h000, 12'h800, 12'h005, 12'h000), 1'b0, '0, 1'b0);
        check("flags_z", {28'b0, Zout}, 32'h1);
        check("flags_n", {28'b0, Nout}, 32'h2);

        // All-mode over all cores; completes only when core3 writes.
        step('0, '0, 1'b1, 4'b1111, 1'b1);
        check("all_busy_rise", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(4'(1 << k), '0, 1'b0, '0, 1'b0);
            check("all_wait_busy", {31'b0, busy}, 32'd1);
            check("all_wait_novalid", {31'b0, decisionValid}, 32'd0);
        end
        step(4'b1000, '0, 1'b0, '0, 1'b0);
        check("all_valid", {31'b0, decisionValid}, 32'd1);
        check("all_decz", {31'b0, decisionZ}, 32'd1);
        idle();
        check("all_pulse_end", {31'b0, decisionValid}, 32'd0);
        check("all_idle", {31'b0, busy}, 32'd0);

        // Fresh was consumed: a core0 query must wait for a new write.
        step('0, '0, 1'b1, 4'b0001, 1'b1);
        idle();
        check("fresh_cleared", {31'b0, decisionValid}, 32'd0);
        step(4'b0001, pack(12'h001, 12'h000, 12'h000, 12'h000), 1'b0, '0, 1'b0);
        check("fresh_valid", {31'b0, decisionValid}, 32'd1);
        check("fresh_decz", {31'b0, decisionZ}, 32'd0);
        idle();

        // Any-mode over cores 0 and 2; unmasked writes never complete it.
        step('0, '0, 1'b1, 4'b0101, 1'b0);
        step(4'b1010, '0, 1'b0, '0, 1'b0);
        check("any_unmasked", {31'b0, decisionValid}, 32'd0);
        idle();
        check("any_still_busy", {31'b0, busy}, 32'd1);
        step(4'b0001, pack(12'h003, 12'h000, 12'h000, 12'h000), 1'b0, '0, 1'b0);
        check("any_partial", {31'b0, decisionValid}, 32'd0);
        step(4'b0100, '0, 1'b0, '0, 1'b0);
        check("any_valid", {31'b0, decisionValid}, 32'd1);
        check("any_decz", {31'b0, decisionZ}, 32'd1);
        idle();

        // Queries while busy are dropped.
        step('0, '0, 1'b1, 4'b0001, 1'b1);
        step('0, '0, 1'b1, 4'b0000, 1'b0);
        step(4'b0001, '0, 1'b0, '0, 1'b0);
        check("dup_valid", {31'b0, decisionValid}, 32'd1);
        check("dup_decz", {31'b0, decisionZ}, 32'd1);
        step('0, '0, 1'b1, 4'b0000, 1'b0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (decisionValid) pulses++;
            idle();
        end
        check("dup_no_extra_pulse", pulses, 32'd0);

        // Write during RESULT keeps fresh[0]; next core0 query decides at t+2.
        step('0, '0, 1'b1, 4'b0001, 1'b1);
        step(4'b0001, '0, 1'b0, '0, 1'b0);
        check("conf_valid", {31'b0, decisionValid}, 32'd1);
        step(4'b0001, pack(12'h007, 12'h000, 12'h000, 12'h000), 1'b0, '0, 1'b0);
        check("conf_idle", {31'b0, busy}, 32'd0);
        check("conf_z0", {31'b0, Zout[0]}, 32'd0);
        step('0, '0, 1'b1, 4'b0001, 1'b1);
        check("conf_t1", {31'b0, decisionValid}, 32'd0);
        idle();
        check("conf_t2_valid", {31'b0, decisionValid}, 32'd1);
        check("conf_t2_decz", {31'b0, decisionZ}, 32'd0);
        idle();

        // Empty mask: vacuous truth in all-mode, false in any-mode.
        step('0, '0, 1'b1, 4'b0000, 1'b1);
        idle();
        check("mask0_all_valid", {31'b0, decisionValid}, 32'd1);
        check("mask0_all_decz", {31'b0, decisionZ}, 32'd1);
        idle();
        step('0, '0, 1'b1, 4'b0000, 1'b0);
        idle();
        check("mask0_any_valid", {31'b0, decisionValid}, 32'd1);
        check("mask0_any_decz", {31'b0, decisionZ}, 32'd0);
        idle();

        // Reset during WAIT aborts the query.
        step('0, '0, 1'b1, 4'b1000, 1'b1);
        idle();
        check("rstwait_busy_before", {31'b0, busy}, 32'd1);
        #1 rst = 1;
        #1;
        check("rstwait_busy", {31'b0, busy}, 32'd0);
        check("rstwait_valid", {31'b0, decisionValid}, 32'd0);
        @(posedge clk); #2 rst = 0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            idle();
            if (decisionValid) pulses++;
        end
        check("rstwait_no_pulse", pulses, 32'd0);
        step('0, '0, 1'b1, 4'b0000, 1'b0);
        idle();
        check("rstwait_idle_again", {31'b0, decisionValid}, 32'd1);
        idle();

`ifdef ZFLAG_TIMEOUT_EN
        // Core1 is never written after reset, so only the timeout ends WAIT.
        step('0, '0, 1'b1, 4'b0010, 1'b1);
        seen = 0; toFlag = 0; toZ = 0;
        for (int k = 1; k <= 3 * TO; k++) begin
            idle();
            if (decisionValid) begin
                seen = k; toFlag = timedOut; toZ = decisionZ;
                break;
            end
        end
        check("timeout_latency", seen, TO);
        check("timeout_flag", {31'b0, toFlag}, 32'd1);
        check("timeout_decz", {31'b0, toZ}, 32'd0);
        idle();
        idle();
`endif

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_zflag_bank
